// File: rtl/proc_pkg.sv
// Shared fetch-side types and constants for the 8-bit multi-cycle core.
// No logic: only the state encoding, opcode field position and width defaults.
// Consumers: the instruction fetch queue, its interface and the control unit.
package proc_pkg;

    localparam int PC_W_DEF = 16;
    localparam int OPC_HI   = 7;
    localparam int OPC_LO   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [7:0] b);
        return b[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch queue bus: program-memory read port plus the instruction handshake.
// master = fetch queue, slave = memory/controller side.
// Backpressure is carried by instr_ready only; memory never stalls.
interface instr_fetch_queue_if
    import proc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            imem_rd;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic [7:0]      instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;

    modport master (
        output imem_rd, imem_addr, instr, instr_pc, instr_valid,
        input  imem_data, instr_ready
    );

    modport slave (
        input  imem_rd, imem_addr, instr, instr_pc, instr_valid,
        output imem_data, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with registered head output and synchronous clear.
// Latency: a push into an empty FIFO is visible on rd_dat the next cycle.
// Backpressure: push is dropped when full unless a pop frees the slot same cycle.
module fetch_fifo #(
    parameter int  W     = 24,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  wr_dat,
    input  logic          pop,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic [W-1:0]  head_q, head_nxt;
    logic          do_push, do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign rd_dat     = head_q;

    // Head is a register so it holds the last value once the FIFO drains.
    always_comb begin
        head_nxt = head_q;
        if (!clr) begin
            if (do_pop) begin
                if (count > CW'(1))
                    head_nxt = mem[rd_ptr_inc];
                else if (do_push)
                    head_nxt = wr_dat;
            end else if (empty && do_push) begin
                head_nxt = wr_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            head_q <= head_nxt;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_inc;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= wr_dat;
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues program-memory reads, buffers {byte, pc}.
// Latency: 2 cycles from first imem_rd to instr_valid; 1 instr/cycle sustained.
// Backpressure: reads are only issued when a FIFO slot is reserved, so no overflow.
module instr_fetch_queue
    import proc_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              DEPTH  = 4,
    parameter logic [PC_W-1:0] RST_PC = '0,
    localparam int             CW     = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                halt,
    input  logic                flush,
    input  logic [PC_W-1:0]     flush_pc,
    output logic [PC_W-1:0]     fetch_pc,
    output logic [CW-1:0]       occupancy,
    instr_fetch_queue_if.master bus
);
    localparam int CW1 = CW + 1;

    fetch_state_t    state_q, state_nxt;
    logic [PC_W-1:0] pc_q, resp_pc_q, issue_addr;
    logic            epoch_q, rd_ep_q, resp_q, resp_ep_q;
    logic            rd_live, push, pop, room, issue;
    logic [CW1-1:0]  committed;
    logic            fifo_empty, fifo_full;
    logic [PC_W+7:0] head;

    // A response is kept only if no flush happened since its read was issued.
    assign rd_live   = (state_q == ST_RUN) && (rd_ep_q == epoch_q);
    assign push      = resp_q && (resp_ep_q == epoch_q) && !flush;
    assign pop       = bus.instr_valid && bus.instr_ready && !flush;
    assign committed = CW1'(occupancy) + CW1'(push) + CW1'(rd_live);
    assign room      = (committed - CW1'(pop)) < CW1'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_RUN;
        if (flush) begin
            if (halt)     state_nxt = ST_HALT;
            else if (!en) state_nxt = ST_IDLE;
        end else if (halt) begin
            state_nxt = ST_HALT;
        end else if (!en) begin
            state_nxt = ST_IDLE;
        end else if (!room) begin
            state_nxt = ST_FULL;
        end
    end

    // The registered state doubles as the read strobe: RUN means a read is out.
    always_comb begin
        bus.imem_rd = (state_q == ST_RUN);
        issue       = (state_nxt == ST_RUN);
        issue_addr  = flush ? flush_pc : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RST_PC;
            bus.imem_addr <= '0;
            rd_ep_q       <= 1'b0;
            resp_q        <= 1'b0;
            resp_ep_q     <= 1'b0;
            resp_pc_q     <= '0;
            epoch_q       <= 1'b0;
        end else begin
            epoch_q   <= epoch_q ^ flush;
            resp_q    <= bus.imem_rd;
            resp_ep_q <= rd_ep_q;
            resp_pc_q <= bus.imem_addr;
            if (issue) begin
                bus.imem_addr <= issue_addr;
                rd_ep_q       <= epoch_q ^ flush;
                pc_q          <= issue_addr + 1'b1;
            end else if (flush) begin
                pc_q <= flush_pc;
            end
        end
    end

    fetch_fifo #(
        .W     (PC_W + 8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .push   (push),
        .wr_dat ({bus.imem_data, resp_pc_q}),
        .pop    (pop),
        .rd_dat (head),
        .count  (occupancy),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign bus.instr       = head[PC_W+7:PC_W];
    assign bus.instr_pc    = head[PC_W-1:0];
    assign bus.instr_valid = !fifo_empty;
    assign fetch_pc        = pc_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random en/halt/flush/ready
// traffic, all checked against an in-order PC stream model.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, halt = 1'b0, flush = 1'b0;
    logic [15:0] flush_pc = 16'h0;
    logic [15:0] fetch_pc;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    instr_fetch_queue_if #(.PC_W(16)) ifc ();

    instr_fetch_queue #(.PC_W(16), .DEPTH(4), .RST_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .halt      (halt),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .fetch_pc  (fetch_pc),
        .occupancy (occupancy),
        .bus       (ifc.master)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous program memory: data valid the cycle after the read strobe.
    always @(posedge clk)
        ifc.imem_data <= ifc.imem_rd ? mb(ifc.imem_addr) : 8'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: instructions leave in strict PC order from the last redirect.
    logic [15:0] exp_issue, exp_pop, prev_fpc, last_pc;
    logic [7:0]  last_instr;
    logic        prev_rd, prev_flush, prev_stall, prev_issue_ok, pop_now;
    int          occ_m, issue_cnt;

    always @(negedge clk) begin
        if (rst) begin
            exp_issue = 16'h0000; exp_pop = 16'h0000; occ_m = 0; issue_cnt = 0;
            prev_rd = 1'b0; prev_flush = 1'b0; prev_stall = 1'b0; prev_issue_ok = 1'b0;
            prev_fpc = 16'h0; last_instr = 8'h0; last_pc = 16'h0;
        end else begin
            if (prev_flush) begin
                exp_issue = prev_fpc;
                chk("flush_rd", ifc.imem_rd, prev_issue_ok);
            end else if (prev_stall) begin
                chk("stall_rd", ifc.imem_rd, 0);
            end
            if (ifc.imem_rd) begin
                chk("issue_addr", ifc.imem_addr, exp_issue);
                exp_issue = exp_issue + 16'h1;
                issue_cnt++;
            end
            chk("occ", occupancy, occ_m);
            chk("valid", ifc.instr_valid, occ_m != 0);
            if (!ifc.instr_valid) begin
                chk("hold_instr", ifc.instr, last_instr);
                chk("hold_pc", ifc.instr_pc, last_pc);
            end else begin
                last_instr = ifc.instr;
                last_pc    = ifc.instr_pc;
            end
            pop_now = ifc.instr_valid && ifc.instr_ready && !flush;
            if (pop_now) begin
                chk("pop_pc", ifc.instr_pc, exp_pop);
                chk("pop_byte", ifc.instr, mb(exp_pop));
                exp_pop = exp_pop + 16'h1;
            end
            if (flush) begin
                occ_m   = 0;
                exp_pop = flush_pc;
            end else begin
                occ_m = occ_m + int'(prev_rd && !prev_flush) - int'(pop_now);
            end
            prev_rd       = ifc.imem_rd;
            prev_flush    = flush;
            prev_stall    = halt || !en;
            prev_issue_ok = en && !halt;
            prev_fpc      = flush_pc;
        end
    end

    task automatic do_reset(input logic en_v, input logic rdy_v);
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b0; halt = 1'b0; en = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; en = en_v; ifc.instr_ready = rdy_v;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!ifc.instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ifc.instr_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"}, ifc.imem_rd, 0);
        chk({tag, "_addr"}, ifc.imem_addr, 0);
        chk({tag, "_valid"}, ifc.instr_valid, 0);
        chk({tag, "_instr"}, ifc.instr, 0);
        chk({tag, "_ipc"}, ifc.instr_pc, 0);
        chk({tag, "_occ"}, occupancy, 0);
        chk({tag, "_fpc"}, fetch_pc, 0);
    endtask

    initial begin
        int hrd, hpop;
        ifc.instr_ready = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("rst0");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; ifc.instr_ready = 1'b1;

        // Startup latency and throughput
        @(negedge clk); chk("c0_rd", ifc.imem_rd, 0);
        @(negedge clk); chk("c1_rd", ifc.imem_rd, 1); chk("c1_addr", ifc.imem_addr, 16'h0);
        @(negedge clk); chk("c2_valid", ifc.instr_valid, 0);
        @(negedge clk); chk("c3_valid", ifc.instr_valid, 1);
        chk("c3_instr", ifc.instr, 8'h00); chk("c3_pc", ifc.instr_pc, 16'h0);
        @(negedge clk); chk("c4_pc", ifc.instr_pc, 16'h1); chk("c4_instr", ifc.instr, 8'h01);
        @(negedge clk); chk("c5_pc", ifc.instr_pc, 16'h2);

        // Fill to full with no consumer, then release
        do_reset(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("full_occ", occupancy, 4);
        chk("full_rd", ifc.imem_rd, 0);
        chk("full_issues", issue_cnt, 4);
        chk("full_head", ifc.instr_pc, 16'h0);
        @(posedge clk); #1 ifc.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("refill_rd", ifc.imem_rd, 1); chk("refill_addr", ifc.imem_addr, 16'h4);

        // Flush with entries queued and a read in flight
        do_reset(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1; flush_pc = 16'h0040;
        @(negedge clk); chk("pre_flush_occ", occupancy, 2); chk("pre_flush_rd", ifc.imem_rd, 1);
        @(posedge clk); #1 flush = 1'b0; ifc.instr_ready = 1'b1;
        @(negedge clk);
        chk("flush_occ", occupancy, 0); chk("flush_valid", ifc.instr_valid, 0);
        chk("flush_addr", ifc.imem_addr, 16'h0040); chk("flush_rd1", ifc.imem_rd, 1);
        wait_valid("flush_wait");
        chk("flush_first_pc", ifc.instr_pc, 16'h0040);
        chk("flush_first_instr", ifc.instr, 8'h40);

        // PC wrap
        @(posedge clk); #1 flush = 1'b1; flush_pc = 16'hFFFF;
        @(posedge clk); #1 flush = 1'b0;
        wait_valid("wrap_wait");
        chk("wrap_pc0", ifc.instr_pc, 16'hFFFF);
        @(negedge clk); chk("wrap_pc1", ifc.instr_pc, 16'h0000);
        @(negedge clk); chk("wrap_pc2", ifc.instr_pc, 16'h0001);

        // Halt for 5 cycles while consuming
        hrd = 0; hpop = 0;
        @(posedge clk); #1 halt = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hrd  += int'(ifc.imem_rd);
            hpop += int'(ifc.instr_valid);
        end
        @(posedge clk); #1 halt = 1'b0;
        @(negedge clk); hrd += int'(ifc.imem_rd);
        chk("halt_rd", hrd, 0);
        chk("halt_drain", hpop > 0, 1);
        repeat (4) @(negedge clk);
        chk("resume_valid", ifc.instr_valid, 1);
        chk("resume_rd", ifc.imem_rd, 1);

        // Asynchronous reset mid-operation
        @(posedge clk); #1 ifc.instr_ready = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        @(posedge clk); #1 rst = 1'b0; ifc.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("restart_rd", ifc.imem_rd, 1); chk("restart_addr", ifc.imem_addr, 16'h0);

        // Random traffic
        repeat (3000) begin
            @(posedge clk); #1;
            en    = ($urandom_range(0, 9) != 0);
            halt  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            flush_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            ifc.instr_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1 flush = 1'b0; halt = 1'b0; en = 1'b1; ifc.instr_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
